alu32_bist_ctrl: RTL

Synthesizable self-test initiator for the 32-bit gate-level ALU (G_ALU32). It replaces file-driven benches with on-chip stimulus.
- Generates pseudo-random operand vectors with an LFSR and drives each opcode to the ALU.
- Compares the ALU outputs against an internal behavioural golden model after a settle window.
- Reports pass/fail, an error count and the first failing vector and opcode.
- Sits beside G_ALU32: its outputs drive In1/In2/CI/A, and FinalOut/CO return to it.

---
 rtl/alu32_bist_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu32_bist_ctrl.sv
// alu32_bist_ctrl: on-chip self-test initiator for the 32-bit gate-level ALU.
// Feeds LFSR-generated operand pairs through all five opcodes. After each
// settle window it checks the returned result against a behavioural golden
// model. It reports pass/fail, a saturating error count and the first
// failing vector/opcode.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start after reset
// GEN    | one cycle: step LFSR twice, load operands, opcode back to AND
// DRIVE  | hold opcode SETTLE_CYCLES+1 cycles, check on the last, advance
// DONE   | results frozen; start launches a fresh run from SEED

module alu32_bist_ctrl #(
    parameter int          NUM_VECTORS   = 1000,
    parameter logic [31:0] SEED          = 32'hACE12021,
    parameter int          SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic        alu_ci,
    output logic [2:0]  alu_a,
    input  logic [31:0] alu_out,
    input  logic        alu_co,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_fail_vec,
    output logic [2:0]  first_fail_op
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] POLY        = 32'h80200003;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES);
    localparam logic [15:0] LAST_VEC    = (NUM_VECTORS > 0) ? 16'(NUM_VECTORS - 1) : 16'd0;
    localparam bit          NO_VECTORS  = (NUM_VECTORS == 0);
    localparam logic [2:0]  OP_AND      = 3'b000;
    localparam logic [2:0]  OP_OR       = 3'b001;
    localparam logic [2:0]  OP_XOR      = 3'b010;
    localparam logic [2:0]  OP_NOT      = 3'b011;
    localparam logic [2:0]  OP_ADD      = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GEN   = 2'd1,
        S_DRIVE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] lfsr;
    logic [15:0] vec_idx;
    logic [3:0]  settle_cnt;

    logic [31:0] lfsr_s1;
    logic [31:0] lfsr_s2;
    logic [32:0] sum;
    logic [31:0] exp_out;
    logic        exp_co;
    logic        mismatch;
    logic        settle_done;

    // Galois step: shift right, fold the polynomial in when a 1 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ POLY;
        end
        return n;
    endfunction

    assign lfsr_s1     = lfsr_step(lfsr);
    assign lfsr_s2     = lfsr_step(lfsr_s1);
    assign settle_done = (settle_cnt == SETTLE_LAST);

    // Golden model of the ALU evaluated on the registered operands.
    always_comb begin
        sum     = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'd0, alu_ci};
        exp_out = 32'd0;
        exp_co  = 1'b0;
        case (alu_a)
            OP_AND:  exp_out = alu_in1 & alu_in2;
            OP_OR:   exp_out = alu_in1 | alu_in2;
            OP_XOR:  exp_out = alu_in1 ^ alu_in2;
            OP_NOT:  exp_out = ~alu_in1;
            OP_ADD: begin
                exp_out = sum[31:0];
                exp_co  = sum[32];
            end
            default: begin
                exp_out = 32'd0;
                exp_co  = 1'b0;
            end
        endcase
    end

    // Carry-out only carries meaning for ADD.
    assign mismatch = (alu_out != exp_out) || ((alu_a == OP_ADD) && (alu_co != exp_co));

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            lfsr           <= SEED_EFF;
            vec_idx        <= 16'd0;
            settle_cnt     <= 4'd0;
            alu_in1        <= 32'd0;
            alu_in2        <= 32'd0;
            alu_ci         <= 1'b0;
            alu_a          <= OP_AND;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'd0;
            first_fail_vec <= 16'd0;
            first_fail_op  <= 3'b000;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_count      <= 16'd0;
                        first_fail_vec <= 16'd0;
                        first_fail_op  <= 3'b000;
                        lfsr           <= SEED_EFF;
                        vec_idx        <= 16'd0;
                        settle_cnt     <= 4'd0;
                        if (NO_VECTORS) begin
                            // Nothing to test: finish immediately with a clean result.
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_GEN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end

                S_GEN: begin
                    alu_in1    <= lfsr_s1;
                    alu_in2    <= lfsr_s2;
                    alu_ci     <= lfsr_s1[0];
                    lfsr       <= lfsr_s2;
                    alu_a      <= OP_AND;
                    settle_cnt <= 4'd0;
                    state      <= S_DRIVE;
                end

                S_DRIVE: begin
                    if (!settle_done) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end else begin
                        if (mismatch) begin
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                            // The count only leaves zero on the first mismatch of a run.
                            if (err_count == 16'd0) begin
                                first_fail_vec <= vec_idx;
                                first_fail_op  <= alu_a;
                            end
                        end
                        settle_cnt <= 4'd0;
                        if (alu_a < OP_ADD) begin
                            alu_a <= alu_a + 3'd1;
                        end else if (vec_idx != LAST_VEC) begin
                            vec_idx <= vec_idx + 16'd1;
                            state   <= S_GEN;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == 16'd0) && !mismatch;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
